// File: rtl/qbv_pkg.sv
// qbv_pkg: shared types and constants for the 802.1Qbv gate control list
// sequencer (qbv_gate_scheduler and qbv_gcl_table).
//   GATE_BV / GATE_LEGACY : bit positions inside a gate mask
//   gcl_entry_t           : one GCL entry {gate[1:0], interval[31:0]}
//   state_t               : sequencer states IDLE / WAIT_BASE / RUN
//   GATES_ALL_OPEN        : admin-default gate mask
//   time_reached()        : wrap-safe "now >= target" on 32-bit PTP ns
package qbv_pkg;

    localparam int unsigned GATE_BV     = 1;
    localparam int unsigned GATE_LEGACY = 0;

    localparam logic [1:0] GATES_ALL_OPEN = 2'b11;

    typedef struct packed {
        logic [1:0]  gate;
        logic [31:0] interval;
    } gcl_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BASE,
        RUN
    } state_t;

    // Signed difference keeps the comparison correct across the 2^32 wrap.
    function automatic logic time_reached(input logic [31:0] now,
                                          input logic [31:0] target);
        return $signed(now - target) >= 0;
    endfunction

endpackage

// File: rtl/qbv_gcl_table.sv
// qbv_gcl_table: NUM_ENTRIES x gcl_entry_t register file holding the gate
// control list. One synchronous write port, asynchronous read ports.
// The next-entry read port only exists when QBV_GUARD_BAND_EN is defined.
//   clk, rst_n           : clock, asynchronous active-low reset (zeroes table)
//   we, wr_addr, wr_data : write port
//   cur_addr, cur_entry  : read port for the entry being (re)loaded
//   next_addr, next_entry: read port for the following entry (guard band only)
module qbv_gcl_table
    import qbv_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_addr,
    input  gcl_entry_t       wr_data,
    input  logic [IDX_W-1:0] cur_addr,
    output gcl_entry_t       cur_entry
`ifdef QBV_GUARD_BAND_EN
    ,
    input  logic [IDX_W-1:0] next_addr,
    output gcl_entry_t       next_entry
`endif
);

    gcl_entry_t mem [NUM_ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign cur_entry = mem[cur_addr];

`ifdef QBV_GUARD_BAND_EN
    assign next_entry = mem[next_addr];
`endif

endmodule

// File: rtl/qbv_gate_scheduler.sv
// qbv_gate_scheduler: 802.1Qbv gate control list sequencer. Walks the
// programmed (gate mask, interval) list against PTP time and drives the
// registered bv / legacy gate states for the time-aware shaper.
// Optional build macro: QBV_GUARD_BAND_EN closes the legacy gate during the
// last GUARD_NS of an entry whose successor has the legacy gate closed.
//   tx_mac_aclk, tx_mac_resetn : clock, asynchronous active-low reset
//   time_ptp_ns                : free-running PTP ns (wraps mod 2^32)
//   cfg_enable                 : 1 = run schedule, 0 = all gates open
//   cfg_base_time              : start time of entry 0 of the first cycle
//   cfg_cycle_time             : cycle length (0 = end after last entry)
//   cfg_num_entries            : active entries, 1..NUM_ENTRIES
//   cfg_we/addr/gate/interval  : table write port (accepted only in IDLE)
//   gate_bv_open/legacy_open   : registered gate states
//   cur_index                  : active entry index
//   cycle_start                : one-clock pulse when entry 0 becomes active
//   cfg_error                  : sticky error, cleared on cfg_enable fall
module qbv_gate_scheduler
    import qbv_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES),
    parameter int unsigned GUARD_NS    = 12304
) (
    input  logic             tx_mac_aclk,
    input  logic             tx_mac_resetn,
    input  logic [31:0]      time_ptp_ns,
    input  logic             cfg_enable,
    input  logic [31:0]      cfg_base_time,
    input  logic [31:0]      cfg_cycle_time,
    input  logic [IDX_W:0]   cfg_num_entries,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [1:0]       cfg_gate,
    input  logic [31:0]      cfg_interval,
    output logic             gate_bv_open,
    output logic             gate_legacy_open,
    output logic [IDX_W-1:0] cur_index,
    output logic             cycle_start,
    output logic             cfg_error
);

    localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(NUM_ENTRIES);

    state_t           state;
    logic             enable_q;
    logic [31:0]      entry_start;
    logic [31:0]      cycle_base;
    logic [31:0]      cur_interval;

    logic [31:0]      entry_end;
    logic [31:0]      cycle_end;
    logic             enable_rise;
    logic             enable_fall;
    logic             num_ok;
    logic             addr_ok;
    logic             tbl_we;
    logic             wr_err;
    logic             last_entry;
    logic             cycle_hit;
    logic             entry_hit;
    logic             guard_hit;
    logic [IDX_W-1:0] step_index;
    logic [IDX_W-1:0] idx_d;
    gcl_entry_t       wr_entry;
    gcl_entry_t       rd_cur;

    always_comb begin
        enable_rise = cfg_enable & ~enable_q;
        enable_fall = ~cfg_enable & enable_q;
        num_ok      = (cfg_num_entries != '0) && (cfg_num_entries <= NUM_MAX);
        addr_ok     = {1'b0, cfg_addr} < NUM_MAX;
        tbl_we      = cfg_we && (state == IDLE) && addr_ok;
        wr_err      = cfg_we && ((state != IDLE) || !addr_ok);
        wr_entry    = '{gate: cfg_gate, interval: cfg_interval};

        entry_end   = entry_start + cur_interval;
        cycle_end   = cycle_base + cfg_cycle_time;
        last_entry  = ({1'b0, cur_index} == (cfg_num_entries - 1'b1));
        step_index  = last_entry ? '0 : cur_index + 1'b1;
        cycle_hit   = (cfg_cycle_time != '0) && time_reached(time_ptp_ns, cycle_end);
        entry_hit   = time_reached(time_ptp_ns, entry_end);

        // The read port is addressed with the index that will be current
        // after this edge, so the new mask and interval register together
        // with cur_index.
        idx_d = cur_index;
        if ((state != RUN) || !cfg_enable) begin
            idx_d = '0;
        end else if (cycle_hit) begin
            idx_d = '0;
        end else if (entry_hit) begin
            idx_d = step_index;
        end
    end

`ifdef QBV_GUARD_BAND_EN
    gcl_entry_t rd_next;

    qbv_gcl_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk        (tx_mac_aclk),
        .rst_n      (tx_mac_resetn),
        .we         (tbl_we),
        .wr_addr    (cfg_addr),
        .wr_data    (wr_entry),
        .cur_addr   (idx_d),
        .cur_entry  (rd_cur),
        .next_addr  (step_index),
        .next_entry (rd_next)
    );

    always_comb begin
        guard_hit = !rd_next.gate[GATE_LEGACY] &&
                    ($signed(entry_end - time_ptp_ns) < $signed(32'(GUARD_NS)));
    end
`else
    qbv_gcl_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk       (tx_mac_aclk),
        .rst_n     (tx_mac_resetn),
        .we        (tbl_we),
        .wr_addr   (cfg_addr),
        .wr_data   (wr_entry),
        .cur_addr  (idx_d),
        .cur_entry (rd_cur)
    );

    always_comb begin
        guard_hit = 1'b0;
    end
`endif

    // enable_q resets to 1 so an enable held high through reset is not
    // mistaken for a rising edge; only a fresh enable restarts the schedule.
    always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
        if (!tx_mac_resetn) begin
            state            <= IDLE;
            enable_q         <= 1'b1;
            entry_start      <= '0;
            cycle_base       <= '0;
            cur_interval     <= '0;
            cur_index        <= '0;
            gate_bv_open     <= 1'b1;
            gate_legacy_open <= 1'b1;
            cycle_start      <= 1'b0;
            cfg_error        <= 1'b0;
        end else begin
            enable_q    <= cfg_enable;
            cycle_start <= 1'b0;
            cur_index   <= idx_d;

            if (enable_fall) begin
                cfg_error <= 1'b0;
            end
            if (wr_err || ((state == IDLE) && enable_rise && !num_ok)) begin
                cfg_error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    gate_bv_open     <= GATES_ALL_OPEN[GATE_BV];
                    gate_legacy_open <= GATES_ALL_OPEN[GATE_LEGACY];
                    if (enable_rise && num_ok) begin
                        state <= WAIT_BASE;
                    end
                end

                WAIT_BASE: begin
                    gate_bv_open     <= GATES_ALL_OPEN[GATE_BV];
                    gate_legacy_open <= GATES_ALL_OPEN[GATE_LEGACY];
                    if (!cfg_enable) begin
                        state <= IDLE;
                    end else if (time_reached(time_ptp_ns, cfg_base_time)) begin
                        entry_start      <= cfg_base_time;
                        cycle_base       <= cfg_base_time;
                        cur_interval     <= rd_cur.interval;
                        gate_bv_open     <= rd_cur.gate[GATE_BV];
                        gate_legacy_open <= rd_cur.gate[GATE_LEGACY];
                        cycle_start      <= 1'b1;
                        state            <= RUN;
                    end
                end

                RUN: begin
                    if (!cfg_enable) begin
                        state            <= IDLE;
                        gate_bv_open     <= GATES_ALL_OPEN[GATE_BV];
                        gate_legacy_open <= GATES_ALL_OPEN[GATE_LEGACY];
                    end else begin
                        cur_interval     <= rd_cur.interval;
                        gate_bv_open     <= rd_cur.gate[GATE_BV];
                        gate_legacy_open <= rd_cur.gate[GATE_LEGACY];
                        if (cycle_hit) begin
                            entry_start <= cycle_end;
                            cycle_base  <= cycle_end;
                            cycle_start <= 1'b1;
                        end else if (entry_hit) begin
                            entry_start <= entry_end;
                            if (last_entry) begin
                                cycle_base  <= entry_end;
                                cycle_start <= 1'b1;
                            end
                        end else if (guard_hit) begin
                            gate_legacy_open <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qbv_gate_scheduler.sv
// tb_qbv_gate_scheduler: directed self-checking bench for qbv_gate_scheduler.
// PTP time advances 8 ns per clock. Observed vector is
// {gate_bv_open, gate_legacy_open, cur_index[2:0], cycle_start, cfg_error}.
module tb_qbv_gate_scheduler;

    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   ptp;
    logic          cfg_enable;
    logic [31:0]   cfg_base_time;
    logic [31:0]   cfg_cycle_time;
    logic [IW:0]   cfg_num_entries;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [1:0]    cfg_gate;
    logic [31:0]   cfg_interval;
    logic          gate_bv_open;
    logic          gate_legacy_open;
    logic [IW-1:0] cur_index;
    logic          cycle_start;
    logic          cfg_error;

    logic [31:0]   last_t;
    logic [6:0]    exp_v;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    qbv_gate_scheduler #(
        .NUM_ENTRIES (8),
        .GUARD_NS    (200)
    ) dut (
        .tx_mac_aclk      (clk),
        .tx_mac_resetn    (rst_n),
        .time_ptp_ns      (ptp),
        .cfg_enable       (cfg_enable),
        .cfg_base_time    (cfg_base_time),
        .cfg_cycle_time   (cfg_cycle_time),
        .cfg_num_entries  (cfg_num_entries),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_gate         (cfg_gate),
        .cfg_interval     (cfg_interval),
        .gate_bv_open     (gate_bv_open),
        .gate_legacy_open (gate_legacy_open),
        .cur_index        (cur_index),
        .cycle_start      (cycle_start),
        .cfg_error        (cfg_error)
    );

    function automatic logic [6:0] snap();
        return {gate_bv_open, gate_legacy_open, cur_index, cycle_start, cfg_error};
    endfunction

    // last_t is the PTP value the DUT sampled at the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
        last_t = ptp;
        ptp    = ptp + 32'd8;
    endtask

    task automatic run_until(input logic [31:0] t);
        int n;
        n = 0;
        while (last_t !== t && n < 4000) begin
            tick();
            n++;
        end
        if (last_t !== t) begin
            $display("FAIL run_until: time %0d never reached, stopped at %0d", t, last_t);
            fails++;
            tests++;
        end
    endtask

    task automatic wr(input logic [IW-1:0] a, input logic [1:0] g, input logic [31:0] iv);
        cfg_addr     = a;
        cfg_gate     = g;
        cfg_interval = iv;
        cfg_we       = 1'b1;
        tick();
        cfg_we       = 1'b0;
    endtask

    task automatic stop();
        cfg_enable = 1'b0;
        tick();
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] cyc,
                         input logic [IW:0] num, input logic [31:0] t0);
        stop();
        tick();
        cfg_base_time   = base;
        cfg_cycle_time  = cyc;
        cfg_num_entries = num;
        ptp             = t0;
        cfg_enable      = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (snap() !== 7'b1100000) begin $display("FAIL reset_values: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
        rst_n = 1'b1;
        tick();
        if (snap() !== 7'b1100000) begin $display("FAIL reset_idle: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
    endtask

    task automatic test_basic_schedule();
        wr(3'd0, 2'b10, 32'd1000);
        wr(3'd1, 2'b01, 32'd3000);
        start(32'd5000, 32'd0, 4'd2, 32'd4000);
        run_until(32'd4992);
        if (snap() !== 7'b1100000) begin $display("FAIL basic_wait: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
        run_until(32'd5000);
        if (snap() !== 7'b1000010) begin $display("FAIL basic_start: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
        run_until(32'd5008);
        if (snap() !== 7'b1000000) begin $display("FAIL basic_pulse_end: got %b want %b", snap(), 7'b1000000); fails++; end
        tests++;
        run_until(32'd5992);
        if (snap() !== 7'b1000000) begin $display("FAIL basic_e0_last: got %b want %b", snap(), 7'b1000000); fails++; end
        tests++;
        run_until(32'd6000);
        if (snap() !== 7'b0100100) begin $display("FAIL basic_e1: got %b want %b", snap(), 7'b0100100); fails++; end
        tests++;
        run_until(32'd8800);
        if (snap() !== 7'b0100100) begin $display("FAIL basic_e1_mid: got %b want %b", snap(), 7'b0100100); fails++; end
        tests++;
        run_until(32'd8992);
`ifdef QBV_GUARD_BAND_EN
        exp_v = 7'b0000100;
`else
        exp_v = 7'b0100100;
`endif
        if (snap() !== exp_v) begin $display("FAIL basic_e1_last: got %b want %b", snap(), exp_v); fails++; end
        tests++;
        run_until(32'd9000);
        if (snap() !== 7'b1000010) begin $display("FAIL basic_wrap: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
    endtask

    task automatic test_truncation();
        start(32'd5000, 32'd2500, 4'd2, 32'd4000);
        run_until(32'd5000);
        if (snap() !== 7'b1000010) begin $display("FAIL trunc_start: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
        run_until(32'd7496);
        if (snap() !== 7'b0100100) begin $display("FAIL trunc_before: got %b want %b", snap(), 7'b0100100); fails++; end
        tests++;
        run_until(32'd7504);
        if (snap() !== 7'b1000010) begin $display("FAIL trunc_wrap: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
        // New cycle base is 7500 (cycle end), so entry 0 ends at 8500.
        run_until(32'd8496);
        if (snap() !== 7'b1000000) begin $display("FAIL trunc_e0_last: got %b want %b", snap(), 7'b1000000); fails++; end
        tests++;
        run_until(32'd8504);
        if (snap() !== 7'b0100100) begin $display("FAIL trunc_e1: got %b want %b", snap(), 7'b0100100); fails++; end
        tests++;
        // Cycle end and entry-0 end coincide: cycle end wins, index stays 0.
        start(32'd5000, 32'd1000, 4'd2, 32'd4000);
        run_until(32'd6000);
        if (snap() !== 7'b1000010) begin $display("FAIL trunc_tie: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
        run_until(32'd6008);
        if (snap() !== 7'b1000000) begin $display("FAIL trunc_tie_next: got %b want %b", snap(), 7'b1000000); fails++; end
        tests++;
        run_until(32'd7000);
        if (snap() !== 7'b1000010) begin $display("FAIL trunc_tie2: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
    endtask

    task automatic test_ptp_wrap();
        start(32'hFFFF_FF00, 32'd0, 4'd2, 32'hFFFF_FE00);
        run_until(32'hFFFF_FEF8);
        if (snap() !== 7'b1100000) begin $display("FAIL wrap_wait: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
        run_until(32'hFFFF_FF00);
        if (snap() !== 7'b1000010) begin $display("FAIL wrap_start: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
        run_until(32'd736);
        if (snap() !== 7'b1000000) begin $display("FAIL wrap_e0_last: got %b want %b", snap(), 7'b1000000); fails++; end
        tests++;
        run_until(32'd744);
        if (snap() !== 7'b0100100) begin $display("FAIL wrap_e1: got %b want %b", snap(), 7'b0100100); fails++; end
        tests++;
        run_until(32'd3744);
        if (snap() !== 7'b1000010) begin $display("FAIL wrap_cycle: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
    endtask

    task automatic test_zero_interval();
        stop();
        wr(3'd1, 2'b00, 32'd0);
        wr(3'd2, 2'b01, 32'd1000);
        start(32'd5000, 32'd0, 4'd3, 32'd4000);
        run_until(32'd5000);
        if (snap() !== 7'b1000010) begin $display("FAIL zero_start: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
        run_until(32'd6000);
        if (snap() !== 7'b0000100) begin $display("FAIL zero_e1: got %b want %b", snap(), 7'b0000100); fails++; end
        tests++;
        run_until(32'd6008);
        if (snap() !== 7'b0101000) begin $display("FAIL zero_e2: got %b want %b", snap(), 7'b0101000); fails++; end
        tests++;
        run_until(32'd6800);
        if (snap() !== 7'b0101000) begin $display("FAIL zero_e2_mid: got %b want %b", snap(), 7'b0101000); fails++; end
        tests++;
        // Entry 2 started at 6000 (not 6008), so the cycle wraps at 7000.
        run_until(32'd7000);
        if (snap() !== 7'b1000010) begin $display("FAIL zero_wrap: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
    endtask

    task automatic test_cfg_errors();
        wr(3'd0, 2'b00, 32'd5);
        if (cfg_error !== 1'b1) begin $display("FAIL err_we_run: got %b want %b", cfg_error, 1'b1); fails++; end
        tests++;
        wr(3'(9), 2'b11, 32'd7);
        if (cfg_error !== 1'b1) begin $display("FAIL err_sticky: got %b want %b", cfg_error, 1'b1); fails++; end
        tests++;
        stop();
        if (snap() !== 7'b1100000) begin $display("FAIL err_disable: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
        cfg_num_entries = 4'd9;
        cfg_enable      = 1'b1;
        tick();
        if (snap() !== 7'b1100001) begin $display("FAIL err_num: got %b want %b", snap(), 7'b1100001); fails++; end
        tests++;
        repeat (3) tick();
        if (snap() !== 7'b1100001) begin $display("FAIL err_num_idle: got %b want %b", snap(), 7'b1100001); fails++; end
        tests++;
        stop();
        if (snap() !== 7'b1100000) begin $display("FAIL err_clear: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
        start(32'd5000, 32'd0, 4'd3, 32'd4000);
        run_until(32'd5000);
        if (snap() !== 7'b1000010) begin $display("FAIL err_tbl_e0: got %b want %b", snap(), 7'b1000010); fails++; end
        tests++;
        run_until(32'd6000);
        if (snap() !== 7'b0000100) begin $display("FAIL err_tbl_e1: got %b want %b", snap(), 7'b0000100); fails++; end
        tests++;
        run_until(32'd6008);
        if (snap() !== 7'b0101000) begin $display("FAIL err_tbl_e2: got %b want %b", snap(), 7'b0101000); fails++; end
        tests++;
    endtask

    task automatic test_async_reset();
        run_until(32'd6400);
        #3;
        rst_n = 1'b0;
        #1;
        if (snap() !== 7'b1100000) begin $display("FAIL areset_now: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
        tick();
        rst_n = 1'b1;
        run_until(32'd7000);
        if (snap() !== 7'b1100000) begin $display("FAIL areset_no_restart: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
    endtask

    task automatic test_guard_band();
        stop();
        wr(3'd0, 2'b11, 32'd1000);
        wr(3'd1, 2'b10, 32'd1000);
        start(32'd5000, 32'd0, 4'd2, 32'd4000);
        run_until(32'd5000);
        if (snap() !== 7'b1100010) begin $display("FAIL guard_start: got %b want %b", snap(), 7'b1100010); fails++; end
        tests++;
        run_until(32'd5800);
        if (snap() !== 7'b1100000) begin $display("FAIL guard_edge: got %b want %b", snap(), 7'b1100000); fails++; end
        tests++;
        run_until(32'd5808);
`ifdef QBV_GUARD_BAND_EN
        exp_v = 7'b1000000;
`else
        exp_v = 7'b1100000;
`endif
        if (snap() !== exp_v) begin $display("FAIL guard_active: got %b want %b", snap(), exp_v); fails++; end
        tests++;
        run_until(32'd6000);
        if (snap() !== 7'b1000100) begin $display("FAIL guard_e1: got %b want %b", snap(), 7'b1000100); fails++; end
        tests++;
        run_until(32'd7000);
        if (snap() !== 7'b1100010) begin $display("FAIL guard_wrap: got %b want %b", snap(), 7'b1100010); fails++; end
        tests++;
    endtask

    initial begin
        rst_n           = 1'b0;
        ptp             = 32'd0;
        last_t          = 32'd0;
        cfg_enable      = 1'b0;
        cfg_base_time   = 32'd0;
        cfg_cycle_time  = 32'd0;
        cfg_num_entries = 4'd2;
        cfg_we          = 1'b0;
        cfg_addr        = '0;
        cfg_gate        = 2'b00;
        cfg_interval    = 32'd0;
        exp_v           = '0;

        test_reset();
        test_basic_schedule();
        test_truncation();
        test_ptp_wrap();
        test_zero_interval();
        test_cfg_errors();
        test_async_reset();
        test_guard_band();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qbv_gate_scheduler.md
Name: qbv_gate_scheduler

Overview:
- Gate control list (GCL) sequencer for the 802.1Qbv transmit path.
- Walks a programmable list of (gate mask, interval) entries against PTP time.
- Drives the open/closed gate state for the bv and legacy streams into the time-aware shaper, which arbitrates the two tx client FIFOs onto the MAC transmit AXI-S port.
- Runs in the MAC transmit clock domain. Configuration is written through a simple synchronous write port by a register front end.

Parameters:
- NUM_ENTRIES, 8: GCL depth. Power of two, 2..64.
- IDX_W, $clog2(NUM_ENTRIES): entry index width.
- GUARD_NS, 12304: guard window in ns. Default is 1538 B at 8 ns/B, i.e. max frame time at 1 Gb/s. Used only under the optional feature.

Ports:
- tx_mac_aclk  in  1  transmit MAC clock (125 MHz); only clock.
- tx_mac_resetn  in  1  asynchronous, active-low reset.
- time_ptp_ns  in  32  PTP nanoseconds; free-running, wraps mod 2^32.
- cfg_enable  in  1  1 = run the schedule; 0 = admin default (all gates open).
- cfg_base_time  in  32  PTP ns at which entry 0 of the first cycle starts.
- cfg_cycle_time  in  32  cycle length in ns; 0 = no truncation, cycle ends after the last entry.
- cfg_num_entries  in  IDX_W+1  active entries, 1..NUM_ENTRIES.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDX_W  table write index.
- cfg_gate  in  2  gate mask to write; bit1 = bv, bit0 = legacy.
- cfg_interval  in  32  entry duration in ns.
- gate_bv_open  out  1  bv stream may start a frame.
- gate_legacy_open  out  1  legacy stream may start a frame.
- cur_index  out  IDX_W  index of the active entry.
- cycle_start  out  1  one-cycle pulse when entry 0 becomes active.
- cfg_error  out  1  sticky error flag; cleared when cfg_enable falls.

Behaviour:
- Reset values: gate_bv_open=1, gate_legacy_open=1, cur_index=0, cycle_start=0, cfg_error=0, state=IDLE. Table contents are zeroed.
- All time comparisons use a signed 32-bit difference, (a-b) as signed >= 0, so they stay correct across the 2^32 wrap. Sums are mod 2^32.

State machine:
- IDLE:
  - Gates are 2'b11.
  - cfg_enable rising goes to WAIT_BASE.
  - If cfg_num_entries is 0 or greater than NUM_ENTRIES, stay in IDLE and set cfg_error.
- WAIT_BASE:
  - Gates stay 2'b11.
  - When time_ptp_ns - cfg_base_time >= 0: latch entry_start = cycle_base = cfg_base_time, cur_index=0, and apply table[0] gates.
  - Pulse cycle_start and go to RUN.
- RUN, on each clock:
  - entry_end = entry_start + table[cur].interval.
  - cycle_end = cycle_base + cfg_cycle_time.
  - If cfg_cycle_time != 0 and time >= cycle_end: wrap to entry 0. This cycle end takes priority over the entry end if both are reached in the same clock.
  - Otherwise, if time >= entry_end: advance to cur+1. After the last active entry (cur = cfg_num_entries-1), wrap to entry 0 instead.
  - On wrap: cycle_base and entry_start are set to cycle_end (truncation case) or entry_end (natural end); cur_index=0; cycle_start pulses.
  - On advance: entry_start = entry_end.
  - At most one index step per clock. Zero-interval entries therefore last exactly one clock.
  - cfg_enable low returns to IDLE on the next clock, with gates 2'b11.
- Latency: gate outputs are registered. The new mask is visible one clock after time_ptp_ns crosses a boundary.
- Table writes:
  - Accepted only while the state is IDLE.
  - cfg_we in WAIT_BASE or RUN is ignored and sets cfg_error.
  - cfg_addr >= NUM_ENTRIES is ignored and sets cfg_error.
- Reset asserted mid-cycle: immediate return to reset values. The schedule restarts only from a new cfg_enable rising edge.
- Gate changes never truncate a frame. The shaper samples gates only at frame start.

Optional Feature:
- QBV_GUARD_BAND_EN defined:
  - gate_legacy_open is forced 0 while (entry_end - time) < GUARD_NS and the next entry's legacy bit is 0.
  - This stops a legacy frame from overrunning into a protected bv window.
  - The next-entry lookup wraps to entry 0 after the last active entry.
- Undefined: gate_legacy_open follows table[cur] bit0 only. The guard logic and the next-entry read port are not built.

Decomposition:
- Package qbv_pkg holds:
  - GATE_BV=1 and GATE_LEGACY=0 bit indices.
  - Typedef gcl_entry_t, a struct of gate[1:0] and interval[31:0].
  - State enum {IDLE, WAIT_BASE, RUN}.
  - GATES_ALL_OPEN=2'b11.
- Sub-module qbv_gcl_table: NUM_ENTRIES x gcl_entry_t register file with one write port and two asynchronous read ports (cur, next).

Test Plan:
- Program {0: 2'b10, 1000}, {1: 2'b01, 3000}, num=2, cycle=0, base=5000; time starts at 4000, +8 per clock -> gates 11 until time 5000, then 10 until 6000, then 01 until 9000; cycle_start pulses at 5000 and 9000.
- Same table, cycle=2500 -> at time 7500 the schedule wraps to entry 0 (truncating entry 1 at 1500 ns); cycle_start pulses.
- base=32'hFFFF_FF00, time starts at 32'hFFFF_FE00 -> start occurs after the wrap at the correct time, and entry ends are computed correctly across 0.
- cfg_we while in RUN, and a write to address 9 with NUM_ENTRIES=8 -> table unchanged and cfg_error=1; cfg_enable low -> cfg_error=0 and gates 11 the next clock.
- Assert tx_mac_resetn low mid-RUN -> all outputs return to reset values asynchronously.
- With QBV_GUARD_BAND_EN and GUARD_NS=200, entry0 {2'b11, 1000} followed by {2'b10, 1000} -> gate_legacy_open drops 200 ns before entry0 ends while gate_bv_open stays 1.
